// File: rtl/mac_dot_ctrl.sv
// Dot-product controller: issues paired activation/weight elements to a
// shared two-lane mac datapath and accumulates its returned products.
// Ports:
//   iClk, iRst            clock, async active-high reset
//   iStart, iLen          job start request and element count
//   iValid, iA1, iA2, iW  element stream in, oReady accepts
//   oMacData / iMacData   registered drive to / results from the mac
//   oSum1, oSum2, oDone   signed results and one-cycle valid pulse
//   oBusy                 job in progress

package mac_dot_pkg;
    localparam int cDataBitW   = 8;
    localparam int cWeightBitW = 8;
    localparam int cProdW      = cDataBitW + cWeightBitW;

    typedef struct packed {
        logic                          dv;
        logic signed [cDataBitW-1:0]   a1;
        logic signed [cDataBitW-1:0]   a2;
        logic signed [cWeightBitW-1:0] w;
    } tMultIn;

    typedef struct packed {
        logic                     dv;
        logic signed [cProdW-1:0] data1;
        logic signed [cProdW-1:0] data2;
    } tMultOut;
endpackage

module mac_dot_ctrl
    import mac_dot_pkg::*;
#(
    parameter int cLenW = 10,
    parameter int cAccW = 32
) (
    input  logic                          iClk,
    input  logic                          iRst,
    input  logic                          iStart,
    input  logic [cLenW-1:0]              iLen,
    input  logic                          iValid,
    input  logic signed [cDataBitW-1:0]   iA1,
    input  logic signed [cDataBitW-1:0]   iA2,
    input  logic signed [cWeightBitW-1:0] iW,
    output logic                          oReady,
    output tMultIn                        oMacData,
    input  tMultOut                       iMacData,
    output logic signed [cAccW-1:0]       oSum1,
    output logic signed [cAccW-1:0]       oSum2,
    output logic                          oDone,
    output logic                          oBusy
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } tState;

    tState state;
    tState state_nxt;

    logic [cLenW-1:0] len_q;
    logic [cLenW:0]   iss_cnt;
    logic [cLenW:0]   ret_cnt;
    logic [cLenW:0]   len_ext;
    logic [cLenW:0]   iss_inc;
    logic             xfer;
    logic             start_ok;
    logic             ret_ok;

    logic signed [cAccW-1:0] ext1;
    logic signed [cAccW-1:0] ext2;

    // Counters are one bit wider than the length so a full-length
    // job reaches the terminal count without wrapping.
    assign len_ext  = {1'b0, len_q};
    assign iss_inc  = iss_cnt + (cLenW+1)'(1);
    assign xfer     = iValid & oReady;
    assign start_ok = (state == IDLE) & iStart;
    // Results are only meaningful while a job is live; anything that
    // trickles back after a reset or completion is dropped.
    assign ret_ok   = iMacData.dv & ((state == RUN) | (state == DRAIN));
    assign ext1     = cAccW'(iMacData.data1);
    assign ext2     = cAccW'(iMacData.data2);

    always_comb begin
        state_nxt = state;
        oReady    = 1'b0;
        oBusy     = 1'b0;
        oDone     = 1'b0;
        unique case (state)
            IDLE: begin
                if (iStart) begin
                    state_nxt = (iLen == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                oBusy  = 1'b1;
                oReady = (iss_cnt < len_ext);
                if (xfer && (iss_inc == len_ext)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                oBusy = 1'b1;
                if (ret_cnt == len_ext) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                oDone     = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state    <= IDLE;
            len_q    <= '0;
            iss_cnt  <= '0;
            ret_cnt  <= '0;
            oSum1    <= '0;
            oSum2    <= '0;
            oMacData <= '0;
        end else begin
            state       <= state_nxt;
            oMacData.dv <= xfer;
            if (xfer) begin
                oMacData.a1 <= iA1;
                oMacData.a2 <= iA2;
                oMacData.w  <= iW;
                iss_cnt     <= iss_inc;
            end
            if (start_ok) begin
                len_q   <= iLen;
                iss_cnt <= '0;
                ret_cnt <= '0;
                oSum1   <= '0;
                oSum2   <= '0;
            end else if (ret_ok) begin
                oSum1   <= oSum1 + ext1;
                oSum2   <= oSum2 + ext2;
                ret_cnt <= ret_cnt + (cLenW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_ctrl.sv
// Bench for mac_dot_ctrl: a variable-latency mac model feeds results
// back; expected sums are queued per job and compared on oDone.
module tb_mac_dot_ctrl;
    import mac_dot_pkg::*;

    logic                    iClk = 1'b0;
    logic                    iRst = 1'b1;
    logic                    iStart = 1'b0;
    logic [9:0]              iLen = '0;
    logic                    iValid = 1'b0;
    logic signed [7:0]       iA1 = '0;
    logic signed [7:0]       iA2 = '0;
    logic signed [7:0]       iW = '0;
    logic                    oReady;
    tMultIn                  oMacData;
    tMultOut                 iMacData;
    logic signed [31:0]      oSum1;
    logic signed [31:0]      oSum2;
    logic                    oDone;
    logic                    oBusy;

    mac_dot_ctrl #(.cLenW(10), .cAccW(32)) dut (
        .iClk    (iClk),
        .iRst    (iRst),
        .iStart  (iStart),
        .iLen    (iLen),
        .iValid  (iValid),
        .iA1     (iA1),
        .iA2     (iA2),
        .iW      (iW),
        .oReady  (oReady),
        .oMacData(oMacData),
        .iMacData(iMacData),
        .oSum1   (oSum1),
        .oSum2   (oSum2),
        .oDone   (oDone),
        .oBusy   (oBusy)
    );

    always #5 iClk = ~iClk;

    // mac model: latency selectable per job, not cleared by DUT reset
    tMultOut pipe [0:7];
    int      lat = 3;
    logic    mac_clr = 1'b1;

    function automatic tMultOut mul(input tMultIn m);
        tMultOut r;
        r.dv    = m.dv;
        r.data1 = m.a1 * m.w;
        r.data2 = m.a2 * m.w;
        return r;
    endfunction

    always @(posedge iClk) begin
        if (mac_clr) begin
            for (int i = 0; i < 8; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= mul(oMacData);
            for (int i = 1; i < 8; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign iMacData = pipe[lat-1];

    typedef struct {
        int s1;
        int s2;
    } exp_t;

    exp_t sbq [$];
    int   nrun  = 0;
    int   nfail = 0;
    int   ndv   = 0;
    int   ndone = 0;
    int   acc1;
    int   acc2;
    logic done_prev = 1'b0;

    task automatic chk(input string tag,
                       input logic signed [31:0] got,
                       input logic signed [31:0] exp);
        nrun++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got %0d want %0d", tag, got, exp);
        end
    endtask

    always @(negedge iClk) begin
        if (!iRst && oMacData.dv) ndv++;
        if (oDone) begin
            ndone++;
            if (sbq.size() == 0) begin
                chk("done_unexp", 1, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("sum1", oSum1, e.s1);
                chk("sum2", oSum2, e.s2);
            end
        end
        if (oDone && done_prev) chk("done_1cyc", 2, 1);
        done_prev = oDone;
    end

    task automatic start(input int len);
        iStart = 1'b1;
        iLen   = 10'(len);
        acc1   = 0;
        acc2   = 0;
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    task automatic send(input int a1, input int a2, input int w);
        logic rdy;
        iValid = 1'b1;
        iA1    = 8'(a1);
        iA2    = 8'(a2);
        iW     = 8'(w);
        acc1   += a1 * w;
        acc2   += a2 * w;
        for (int k = 0; k < 100; k++) begin
            rdy = oReady;
            @(negedge iClk);
            if (rdy) begin
                iValid = 1'b0;
                return;
            end
        end
        iValid = 1'b0;
        chk("send_tmo", 0, 1);
    endtask

    task automatic push_exp();
        exp_t e;
        e.s1 = acc1;
        e.s2 = acc2;
        sbq.push_back(e);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            @(negedge iClk);
            if (oDone) return;
        end
        chk("done_tmo", 0, 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge iClk);
    endtask

    int dv0;
    int dn0;
    logic pat [7] = '{1, 0, 0, 1, 1, 0, 1};

    initial begin
        idle(3);
        chk("rst_ready", oReady, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_done", oDone, 0);
        chk("rst_mac", oMacData, 0);
        chk("rst_sum1", oSum1, 0);
        chk("rst_sum2", oSum2, 0);
        iRst    = 1'b0;
        mac_clr = 1'b0;
        idle(2);

        // three max-positive elements back to back
        lat = 3;
        dv0 = ndv;
        start(3);
        chk("run_busy", oBusy, 1);
        repeat (3) send(127, 127, 127);
        push_exp();
        chk("s40_e1", acc1, 48387);
        wait_done();
        idle(4);
        chk("s40_dv", ndv - dv0, 3);
        chk("hold_sum1", oSum1, 48387);
        chk("hold_busy", oBusy, 0);

        // negative products, latency 1
        lat = 1;
        start(2);
        send(127, -127, -127);
        send(-127, -127, 127);
        push_exp();
        chk("s41_e1", acc1, -32258);
        wait_done();
        idle(3);

        // valid gaps
        lat = 2;
        dv0 = ndv;
        start(4);
        acc1 = 4;
        acc2 = 8;
        iA1  = 8'sd1;
        iA2  = 8'sd2;
        iW   = 8'sd1;
        for (int i = 0; i < 7; i++) begin
            iValid = pat[i];
            @(negedge iClk);
        end
        iValid = 1'b0;
        push_exp();
        wait_done();
        idle(4);
        chk("s42_dv", ndv - dv0, 4);

        // start during RUN is ignored
        lat = 4;
        dn0 = ndone;
        start(2);
        send(1, 1, 1);
        iStart = 1'b1;
        iLen   = 10'd5;
        @(negedge iClk);
        iStart = 1'b0;
        chk("s43_ready", oReady, 1);
        send(1, 1, 1);
        push_exp();
        wait_done();
        idle(12);
        chk("s43_ndone", ndone - dn0, 1);
        chk("s43_busy", oBusy, 0);

        // zero-length job
        dv0 = ndv;
        start(0);
        push_exp();
        chk("s44_done", oDone, 1);
        idle(1);
        chk("s44_done_off", oDone, 0);
        idle(3);
        chk("s44_dv", ndv - dv0, 0);

        // reset during DRAIN
        lat = 5;
        dn0 = ndone;
        start(8);
        repeat (8) send(3, 3, 3);
        chk("s45_drain_busy", oBusy, 1);
        chk("s45_drain_rdy", oReady, 0);
        iRst = 1'b1;
        #1;
        chk("s45_rst_busy", oBusy, 0);
        chk("s45_rst_mac", oMacData, 0);
        chk("s45_rst_sum1", oSum1, 0);
        chk("s45_rst_sum2", oSum2, 0);
        @(negedge iClk);
        iRst = 1'b0;
        idle(10);
        chk("s45_stray_sum", oSum1, 0);
        chk("s45_stray_done", ndone - dn0, 0);
        start(1);
        send(2, 2, 2);
        push_exp();
        wait_done();
        idle(3);

        chk("sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", nrun, nfail);
        $finish;
    end

endmodule
